// File: rtl/rcu_pll_seq.sv
// rcu_pll_seq: glitch-safe PLL reconfiguration sequencer (bypass, power down, reprogram, relock, switch back).
module rcu_pll_seq #(
  parameter int CFG_WIDTH    = 3,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_STABLE  = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [CFG_WIDTH-1:0] req_cfg_i,
  output logic                 req_ready_o,
  input  logic                 pll_lock_i,
  output logic                 pll_en_o,
  output logic [CFG_WIDTH-1:0] core_cfg_o,
  output logic                 bypass_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int DW = $clog2(SETTLE_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, BYP, PDN, CFG, PUP, SWB, DONE} state_e;
  state_e               state_q;
  logic [DW-1:0]        dcnt_q;
  logic [SW-1:0]        scnt_q;
  logic [TW-1:0]        tcnt_q;
  logic [CFG_WIDTH-1:0] cfg_q;
  logic                 running_q;
  logic                 dwell_end;
  logic                 lock_ok;
  logic                 timeout;
  assign dwell_end = dcnt_q == DW'(SETTLE_CYC - 1);
  assign lock_ok   = pll_lock_i && scnt_q == SW'(LOCK_STABLE - 1);
  assign timeout   = tcnt_q == TW'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pll_en_o    <= 1'b0;
      core_cfg_o  <= '0;
      bypass_o    <= 1'b1;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      running_q   <= 1'b0;
      dcnt_q      <= '0;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      cfg_q       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            // already running locked at the requested code: nothing to reprogram
            if (running_q && pll_lock_i && req_cfg_i == core_cfg_o) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q   <= BYP;
              cfg_q     <= req_cfg_i;
              err_o     <= 1'b0;
              bypass_o  <= 1'b1;
              running_q <= 1'b0;
              dcnt_q    <= '0;
            end
          end else if (running_q && !pll_lock_i) begin
            bypass_o  <= 1'b1;
            err_o     <= 1'b1;
            running_q <= 1'b0;
          end
        end
        BYP: begin
          dcnt_q <= dwell_end ? '0 : dcnt_q + 1'b1;
          if (dwell_end) begin
            state_q  <= PDN;
            pll_en_o <= 1'b0;
          end
        end
        PDN: begin
          dcnt_q <= dwell_end ? '0 : dcnt_q + 1'b1;
          if (dwell_end) begin
            state_q    <= CFG;
            core_cfg_o <= cfg_q;
          end
        end
        CFG: begin
          state_q  <= PUP;
          pll_en_o <= 1'b1;
          tcnt_q   <= '0;
          scnt_q   <= '0;
        end
        PUP: begin
          // a stable lock beats a timeout landing on the same cycle
          if (lock_ok) begin
            state_q  <= SWB;
            bypass_o <= 1'b0;
            dcnt_q   <= '0;
          end else if (timeout) begin
            state_q   <= DONE;
            done_o    <= 1'b1;
            pll_en_o  <= 1'b0;
            err_o     <= 1'b1;
            running_q <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
            scnt_q <= pll_lock_i ? scnt_q + 1'b1 : '0;
          end
        end
        SWB: begin
          dcnt_q <= dcnt_q + 1'b1;
          if (!pll_lock_i) begin
            state_q   <= DONE;
            done_o    <= 1'b1;
            bypass_o  <= 1'b1;
            err_o     <= 1'b1;
            running_q <= 1'b0;
          end else if (dwell_end) begin
            state_q   <= DONE;
            done_o    <= 1'b1;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
